boot_loader: RTL and testbench

//   Serial program loader sitting upstream of the Hack CPU and its instruction ROM.

---
 rtl/boot_loader.sv | 167 ++++++++++++++++
 tb/tb_boot_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - serial frame loader that writes 16-bit words into the instruction ROM
module boot_loader #(
    parameter int ADDR_W         = 15,
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter bit RUN_ON_RESET   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              loading,
    output logic              done,
    output logic              error
);

    // Word count and index need one bit more than the address so a full
    // 2**ADDR_W image can be counted, and at least 17 bits to hold any N.
    localparam int               CNT_W     = (ADDR_W >= 16) ? ADDR_W + 1 : 17;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;
    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAGIC     = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM
    } state_t;

    state_t             state_q;
    logic [7:0]         len_hi_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   idx_q;
    logic [7:0]         word_hi_q;
    logic [7:0]         csum_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               rom_we_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [15:0]        rom_wdata_q;
    logic               cpu_reset_q;
    logic               loading_q;
    logic               done_q;
    logic               error_q;

    logic [CNT_W-1:0]   len_d;
    logic [CNT_W-1:0]   idx_d;
    logic [7:0]         csum_d;

    assign len_d  = CNT_W'({len_hi_q, rx_data});
    assign idx_d  = idx_q + CNT_W'(1);
    assign csum_d = csum_q + rx_data;

    // Frame parser, ROM write port, CPU hold and inter-byte timeout in one FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN_ON_RESET ? S_RUN : S_IDLE;
            len_hi_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            word_hi_q   <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            loading_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            rom_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_RUN: begin
                    tmo_q <= '0;
                    if (rx_valid && rx_data == MAGIC) begin
                        state_q     <= S_LEN_HI;
                        error_q     <= 1'b0;
                        idx_q       <= '0;
                        rom_addr_q  <= '0;
                        csum_q      <= '0;
                        cpu_reset_q <= 1'b1;
                        loading_q   <= 1'b1;
                    end else begin
                        // Releases the CPU the cycle after reset when booting into RUN
                        cpu_reset_q <= (state_q == S_IDLE);
                    end
                end
                default: begin
                    if (rx_valid) begin
                        tmo_q  <= '0;
                        csum_q <= csum_d;
                        case (state_q)
                            S_LEN_HI: begin
                                len_hi_q <= rx_data;
                                state_q  <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                len_q <= len_d;
                                if (len_d > MAX_WORDS) begin
                                    state_q   <= S_IDLE;
                                    error_q   <= 1'b1;
                                    loading_q <= 1'b0;
                                end else if (len_d == '0) begin
                                    state_q <= S_CSUM;
                                end else begin
                                    state_q <= S_DATA_HI;
                                end
                            end
                            S_DATA_HI: begin
                                word_hi_q <= rx_data;
                                state_q   <= S_DATA_LO;
                            end
                            S_DATA_LO: begin
                                rom_we_q    <= 1'b1;
                                rom_wdata_q <= {word_hi_q, rx_data};
                                rom_addr_q  <= idx_q[ADDR_W-1:0];
                                idx_q       <= idx_d;
                                state_q     <= (idx_d == len_q) ? S_CSUM : S_DATA_HI;
                            end
                            S_CSUM: begin
                                loading_q <= 1'b0;
                                if (rx_data == csum_q) begin
                                    state_q     <= S_RUN;
                                    cpu_reset_q <= 1'b0;
                                    done_q      <= 1'b1;
                                end else begin
                                    state_q <= S_IDLE;
                                    error_q <= 1'b1;
                                end
                            end
                            default: begin
                                state_q   <= S_IDLE;
                                loading_q <= 1'b0;
                            end
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        // Abandon the frame; words already written stay in ROM
                        state_q   <= S_IDLE;
                        error_q   <= 1'b1;
                        loading_q <= 1'b0;
                        tmo_q     <= '0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
            endcase
        end
    end

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign loading   = loading_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader
module tb_boot_loader;

    localparam int AW  = 4;
    localparam int TMO = 40;
    localparam int MAXW = 1 << AW;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_reset;
    logic          loading;
    logic          done;
    logic          error;

    boot_loader #(
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TMO),
        .RUN_ON_RESET   (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .loading   (loading),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] wa[$];
    logic [15:0]   wd[$];
    int            done_cnt = 0;
    int            hold_viol = 0;

    always @(negedge clk) begin
        if (rom_we) begin
            wa.push_back(rom_addr);
            wd.push_back(rom_wdata);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (loading && !cpu_reset) hold_viol <= hold_viol + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_frame(input string nm, input logic [15:0] ew[$],
                               input bit ed, input bit ee, input bit ec);
        check({nm, ".nwrites"}, wd.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wd.size(); i++) begin
            check($sformatf("%s.addr%0d", nm, i), 32'(wa[i]), i);
            check($sformatf("%s.data%0d", nm, i), 32'(wd[i]), 32'(ew[i]));
        end
        check({nm, ".done_pulses"}, done_cnt, 32'(ed));
        check({nm, ".error"}, 32'(error), 32'(ee));
        check({nm, ".cpu_reset"}, 32'(cpu_reset), 32'(ec));
        check({nm, ".loading"}, 32'(loading), 0);
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          nb;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
        bit          exp_done;
        bit          exp_err;
        bit          exp_cpu;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    // Reference model: builds a frame from random words, sums the bytes after
    // the magic, optionally corrupts the checksum, and predicts the outcome.
    task automatic run_random_frame(input int idx, input int forced_n);
        int          n;
        bit          bad;
        bit          oversize;
        logic [7:0]  sum;
        logic [15:0] w;
        logic [15:0] ew[$];
        int          gap;

        n        = (forced_n >= 0) ? forced_n : $urandom_range(0, MAXW + 2);
        bad      = ($urandom_range(0, 3) == 0);
        oversize = (n > MAXW);
        sum      = 8'(n >> 8) + 8'(n);
        clear_mon();
        gap = $urandom_range(0, 2);
        send_byte(8'hA5, gap);
        send_byte(8'(n >> 8), gap);
        send_byte(8'(n), gap);
        if (!oversize) begin
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                ew.push_back(w);
                sum = sum + w[15:8] + w[7:0];
                gap = ($urandom_range(0, 9) == 0) ? TMO - 3 : $urandom_range(0, 2);
                send_byte(w[15:8], gap);
                send_byte(w[7:0], gap);
            end
            send_byte(bad ? sum + 8'($urandom_range(1, 255)) : sum, 0);
        end
        repeat (3) @(negedge clk);
        check_frame($sformatf("rand%0d_n%0d", idx, n), ew,
                    !oversize && !bad, oversize || bad, oversize || bad);
    endtask

    initial begin
        logic [63:0] bv;
        logic [15:0] ew[$];

        vec[0] = '{64'hA500_0212_34AB_CDC0, 8, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0};
        vec[1] = '{64'hA500_0212_34AB_CD6F, 8, 2, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b1};
        vec[2] = '{64'hA500_0212_34AB_CDC0, 8, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b0};
        vec[3] = '{64'hA500_0000_0000_0000, 4, 0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vec[4] = '{64'hA500_1100_0000_0000, 3, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
        vec[5] = '{64'hA500_01A5_A54B_0000, 6, 1, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 1'b0};
        vec[6] = '{64'h1234_0000_0000_0000, 2, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vec[7] = '{64'hA500_0212_34AB_CD6E, 8, 2, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b1};
        vec[8] = '{64'h005A_0000_0000_0000, 2, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
        vec[9] = '{64'hA501_0000_0000_0000, 3, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst.cpu_reset", 32'(cpu_reset), 1);
        check("rst.rom_we", 32'(rom_we), 0);
        check("rst.rom_addr", 32'(rom_addr), 0);
        check("rst.rom_wdata", 32'(rom_wdata), 0);
        check("rst.loading", 32'(loading), 0);
        check("rst.done", 32'(done), 0);
        check("rst.error", 32'(error), 0);
        clear_mon();
        reset = 1'b0;
        @(negedge clk);
        check("run_on_reset.cpu_reset", 32'(cpu_reset), 0);
        repeat (3) @(negedge clk);
        check("run_on_reset.nwrites", wd.size(), 0);

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            clear_mon();
            bv = vec[v].bytes;
            for (int i = 0; i < vec[v].nb; i++) send_byte(bv[63-8*i -: 8], 0);
            repeat (3) @(negedge clk);
            ew.delete();
            if (vec[v].nw > 0) ew.push_back(vec[v].w0);
            if (vec[v].nw > 1) ew.push_back(vec[v].w1);
            check_frame($sformatf("vec%0d", v), ew, vec[v].exp_done, vec[v].exp_err, vec[v].exp_cpu);
        end

        // CPU held from the cycle after the magic byte
        clear_mon();
        send_byte(8'hA5, 0);
        check("magic.cpu_reset", 32'(cpu_reset), 1);
        check("magic.loading", 32'(loading), 1);
        check("magic.error_cleared", 32'(error), 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 2);
        ew.delete();
        check_frame("zero_after_error", ew, 1'b1, 1'b0, 1'b0);

        // Timeout after a partial word
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        repeat (TMO - 1) @(negedge clk);
        check("tmo.loading_before", 32'(loading), 1);
        check("tmo.error_before", 32'(error), 0);
        @(negedge clk);
        check("tmo.error", 32'(error), 1);
        check("tmo.loading", 32'(loading), 0);
        send_byte(8'h34, 3);
        ew.delete();
        check_frame("tmo_late_byte", ew, 1'b0, 1'b1, 1'b1);

        // Reset between the bytes of a word
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.cpu_reset", 32'(cpu_reset), 1);
        check("midrst.loading", 32'(loading), 0);
        check("midrst.error", 32'(error), 0);
        check("midrst.rom_wdata", 32'(rom_wdata), 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst.cpu_released", 32'(cpu_reset), 0);
        send_byte(8'hA5, 0);
        check("midrst.restart_loading", 32'(loading), 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 2);
        ew.delete();
        check_frame("midrst_frame", ew, 1'b1, 1'b0, 1'b0);

        // Randomized frames against the model, with the size limit forced first
        run_random_frame(0, MAXW);
        run_random_frame(1, MAXW + 1);
        for (int r = 2; r < 26; r++) run_random_frame(r, -1);

        check("cpu_held_while_loading", hold_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
